// File: rtl/isr_sequencer.sv
// isr_sequencer: buffers 64-bit operands and drives the integer square root unit one job at a time.
// Optional remainder output out_rem is built when the macro ISR_SEQ_REM_EN is defined.
module isr_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [63:0]       in_value,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_root,
  output logic [63:0]       out_value,
`ifdef ISR_SEQ_REM_EN
  output logic [32:0]       out_rem,
`endif
  output logic [CNT_W-1:0]  job_count,
  output logic              isr_reset,
  output logic [63:0]       isr_value,
  input  logic [31:0]       isr_result,
  input  logic              isr_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      CNT_ZERO = (AW+1)'(0);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW-1:0]    PTR_ZERO = AW'(0);
  localparam logic [CNT_W-1:0] JOB_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] JOB_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [63:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_next_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [31:0]       out_root_r;
  logic [63:0]       out_value_r;
  logic [CNT_W-1:0]  job_count_r;
  logic              isr_reset_r;
  logic [63:0]       isr_value_r;
  logic              push_s;
  logic              pop_s;
  logic              capture_s;
  logic              accept_s;

  // Handshake decode and FIFO occupancy update.
  always_comb begin
    push_s       = in_valid && in_ready_r;
    accept_s     = out_valid_r && out_ready;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Job sequencing: a finished root waits in RUN until the output register can take it.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s        = 1'b1;
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: state_next_s = RUN;
      RUN: begin
        if (isr_done && (!out_valid_r || out_ready)) begin
          capture_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand storage; contents are don't-care until written, pointers define validity.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_value;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != FULL_CNT);
    end
  end

  // ISR drive and result register.
  always_ff @(posedge clock) begin
    if (reset) begin
      isr_reset_r <= 1'b1;
      isr_value_r <= 64'd0;
      out_valid_r <= 1'b0;
      out_root_r  <= 32'd0;
      out_value_r <= 64'd0;
      job_count_r <= JOB_ZERO;
    end else begin
      isr_reset_r <= (state_next_s != RUN);
      if (pop_s) begin
        isr_value_r <= mem_r[rd_ptr_r];
      end
      if (capture_s) begin
        out_root_r  <= isr_result;
        out_value_r <= isr_value_r;
        out_valid_r <= 1'b1;
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s) begin
        job_count_r <= job_count_r + JOB_ONE;
      end
    end
  end

`ifdef ISR_SEQ_REM_EN
  // The remainder is at most 2*root, so the low 33 bits of the difference are exact.
  logic [32:0] square_s;
  logic [32:0] out_rem_r;
  assign square_s = {1'b0, isr_result} * {1'b0, isr_result};

  // Remainder captured together with the root.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_rem_r <= 33'd0;
    end else if (capture_s) begin
      out_rem_r <= isr_value_r[32:0] - square_s;
    end
  end
  assign out_rem = out_rem_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_root  = out_root_r;
  assign out_value = out_value_r;
  assign job_count = job_count_r;
  assign isr_reset = isr_reset_r;
  assign isr_value = isr_value_r;

endmodule

// File: tb/tb_isr_sequencer.sv
// tb_isr_sequencer: randomized bench with an ISR stand-in and a queue-based reference model.
module tb_isr_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [63:0]   in_value = 64'd0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_root;
  logic [63:0]   out_value;
`ifdef ISR_SEQ_REM_EN
  logic [32:0]   out_rem;
`endif
  logic [CW-1:0] job_count;
  logic          isr_reset;
  logic [63:0]   isr_value;
  logic [31:0]   isr_result = 32'd0;
  logic          isr_done = 1'b0;

  logic [63:0]   isr_op = 64'd0;
  int unsigned   isr_cnt = 0;

  int            checks = 0;
  int            failures = 0;
  logic [63:0]   exp_q[$];
  logic [31:0]   got_roots[$];
  logic [32:0]   got_rems[$];
  int            n_acc = 0;
  logic [CW-1:0] exp_jobs = 16'd0;
  bit            rand_rdy = 1'b0;
  bit            rdy_fixed = 1'b1;

  isr_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_root(out_root), .out_value(out_value),
`ifdef ISR_SEQ_REM_EN
    .out_rem(out_rem),
`endif
    .job_count(job_count),
    .isr_reset(isr_reset), .isr_value(isr_value),
    .isr_result(isr_result), .isr_done(isr_done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [32:0]  lo;
    logic [32:0]  hi;
    logic [32:0]  mid;
    logic [127:0] m;
    lo = 33'd0;
    hi = 33'h1_0000_0000;
    while (hi - lo > 33'd1) begin
      mid = (lo + hi) >> 1;
      m = 128'(mid);
      if (m * m <= 128'(v)) lo = mid;
      else hi = mid;
    end
    return lo[31:0];
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ISR stand-in: loads on reset, finishes after a random 1..4 cycles, holds its result.
  always @(posedge clock) begin
    if (isr_reset) begin
      isr_op   <= isr_value;
      isr_cnt  <= $urandom_range(1, 4);
      isr_done <= 1'b0;
    end else if (isr_cnt != 0) begin
      isr_cnt <= isr_cnt - 1;
    end else begin
      isr_done   <= 1'b1;
      isr_result <= isqrt(isr_op);
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Scoreboard: sample handshakes mid-cycle; they take effect at the next rising edge.
  initial forever begin
    logic [63:0]  ev;
    logic [127:0] r;
    @(negedge clock);
    if (reset) begin
      exp_q.delete();
      exp_jobs = 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        n_acc++;
        exp_jobs = exp_jobs + 16'd1;
        got_roots.push_back(out_root);
`ifdef ISR_SEQ_REM_EN
        got_rems.push_back(out_rem);
`endif
        check_eq("out_has_job", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          ev = exp_q.pop_front();
          r  = 128'(out_root);
          check_eq("order_value", 128'(out_value), 128'(ev));
          check_eq("root", 128'(out_root), 128'(isqrt(ev)));
          check_eq("sq_lo", 128'(r * r <= 128'(out_value)), 128'd1);
          check_eq("sq_hi", 128'((r + 1) * (r + 1) > 128'(out_value)), 128'd1);
`ifdef ISR_SEQ_REM_EN
          check_eq("rem", 128'(out_rem), 128'(ev) - 128'(isqrt(ev)) * 128'(isqrt(ev)));
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_value);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_op(input logic [63:0] v);
    bit acc;
    int i;
    acc = 1'b0;
    i = 0;
    in_valid = 1'b1;
    in_value = v;
    while (!acc && i < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      i++;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("push_timeout", 128'(acc), 128'd1);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < budget) begin
      cycles(1);
      i++;
    end
    check_eq("drain_q", 128'(exp_q.size()), 128'd0);
    check_eq("drain_ov", 128'(out_valid), 128'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] rr;
    logic [63:0] v;

    // Reset state
    reset = 1'b1;
    cycles(3);
    check_eq("rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_out_root", 128'(out_root), 128'd0);
    check_eq("rst_out_value", 128'(out_value), 128'd0);
    check_eq("rst_job_count", 128'(job_count), 128'd0);
    check_eq("rst_isr_reset", 128'(isr_reset), 128'd1);
    check_eq("rst_isr_value", 128'(isr_value), 128'd0);
`ifdef ISR_SEQ_REM_EN
    check_eq("rst_out_rem", 128'(out_rem), 128'd0);
`endif
    reset = 1'b0;
    cycles(1);
    check_eq("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Single job 9 with latency of the issue sequence
    got_roots.delete();
    got_rems.delete();
    push_op(64'd9);
    check_eq("lat_idle_isr_reset", 128'(isr_reset), 128'd1);
    cycles(1);
    check_eq("lat_load_isr_reset", 128'(isr_reset), 128'd1);
    check_eq("lat_load_isr_value", 128'(isr_value), 128'd9);
    cycles(1);
    check_eq("lat_run_isr_reset", 128'(isr_reset), 128'd0);
    wait_drain(200);
    check_eq("t1_count", 128'(got_roots.size()), 128'd1);
    if (got_roots.size() >= 1) check_eq("t1_root", 128'(got_roots[0]), 128'd3);
`ifdef ISR_SEQ_REM_EN
    if (got_rems.size() >= 1) check_eq("t1_rem", 128'(got_rems[0]), 128'd0);
`endif
    check_eq("t1_job_count", 128'(job_count), 128'd1);

    // Back-to-back 121, 258, 0
    got_roots.delete();
    got_rems.delete();
    push_op(64'd121);
    push_op(64'd258);
    push_op(64'd0);
    wait_drain(300);
    check_eq("t2_count", 128'(got_roots.size()), 128'd3);
    if (got_roots.size() >= 3) begin
      check_eq("t2_root0", 128'(got_roots[0]), 128'd11);
      check_eq("t2_root1", 128'(got_roots[1]), 128'd16);
      check_eq("t2_root2", 128'(got_roots[2]), 128'd0);
    end
`ifdef ISR_SEQ_REM_EN
    if (got_rems.size() >= 3) begin
      check_eq("t2_rem0", 128'(got_rems[0]), 128'd0);
      check_eq("t2_rem1", 128'(got_rems[1]), 128'd2);
      check_eq("t2_rem2", 128'(got_rems[2]), 128'd0);
    end
`endif

    // All-ones operand
    got_roots.delete();
    got_rems.delete();
    push_op(64'hFFFF_FFFF_FFFF_FFFF);
    wait_drain(200);
    if (got_roots.size() >= 1) check_eq("t3_root", 128'(got_roots[0]), 128'hFFFF_FFFF);
    else check_eq("t3_count", 128'(got_roots.size()), 128'd1);
`ifdef ISR_SEQ_REM_EN
    if (got_rems.size() >= 1) check_eq("t3_rem", 128'(got_rems[0]), 128'h1_FFFF_FFFE);
`endif

    // Backpressure: FIFO fills, second job stalls in RUN with done high
    rdy_fixed = 1'b0;
    cycles(2);
    n0 = n_acc;
    for (int i = 0; i < DEPTH + 2; i++) push_op({$urandom, $urandom});
    for (int i = 0; i < 100 && !(out_valid && isr_done); i++) cycles(1);
    cycles(5);
    check_eq("stall_in_ready", 128'(in_ready), 128'd0);
    check_eq("stall_out_valid", 128'(out_valid), 128'd1);
    check_eq("stall_isr_done", 128'(isr_done), 128'd1);
    check_eq("stall_isr_reset", 128'(isr_reset), 128'd0);
    check_eq("stall_no_accept", 128'(n_acc - n0), 128'd0);
    rdy_fixed = 1'b1;
    wait_drain(500);
    check_eq("stall_all_out", 128'(n_acc - n0), 128'(DEPTH + 2));

    // Reset while RUN with two operands queued
    push_op(64'd49);
    push_op(64'd50);
    push_op(64'd51);
    check_eq("mid_rst_in_run", 128'(isr_reset), 128'd0);
    n0 = n_acc;
    reset = 1'b1;
    cycles(1);
    check_eq("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("mid_rst_isr_reset", 128'(isr_reset), 128'd1);
    reset = 1'b0;
    cycles(1);
    check_eq("mid_rst_in_ready", 128'(in_ready), 128'd1);
    cycles(20);
    check_eq("mid_rst_fifo_empty", 128'(isr_reset), 128'd1);
    check_eq("mid_rst_no_output", 128'(n_acc - n0), 128'd0);
    got_roots.delete();
    got_rems.delete();
    push_op(64'd16);
    wait_drain(200);
    if (got_roots.size() >= 1) check_eq("mid_rst_root16", 128'(got_roots[0]), 128'd4);
    else check_eq("mid_rst_count", 128'(got_roots.size()), 128'd1);

    // 100 random operands with random backpressure, from a fresh reset
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(1);
    n0 = n_acc;
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 3))
        0: v = {$urandom, $urandom};
        1: v = 64'($urandom_range(0, 1000));
        2: begin
          rr = $urandom;
          v = 64'(rr) * 64'(rr) - 64'($urandom_range(0, 1));
        end
        default: v = {1'b1, 31'($urandom), $urandom};
      endcase
      cycles($urandom_range(0, 2));
      push_op(v);
    end
    wait_drain(5000);
    rand_rdy = 1'b0;
    check_eq("rand_accepts", 128'(n_acc - n0), 128'd100);
    check_eq("rand_job_count", 128'(job_count), 128'd100);
    check_eq("rand_job_model", 128'(job_count), 128'(exp_jobs));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
